// File: rtl/qpu_exu_alu_req_arb_pkg.sv
// Shared constants for the EXU ALU request arbiter: requestor ids, func bit
// positions, FSM encoding and a one-hot helper.
`ifndef QPU_XLEN
`define QPU_XLEN 32
`endif

package qpu_exu_alu_arb_pkg;

  localparam int NREQ = 4;

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_BJP = 2'd1;
  localparam logic [1:0] REQ_LSU = 2'd2;
  localparam logic [1:0] REQ_QIU = 2'd3;

  localparam int ALU_ADD_BIT = 3;
  localparam int ALU_OR_BIT  = 2;
  localparam int ALU_XOR_BIT = 1;
  localparam int ALU_AND_BIT = 0;

  localparam int BJP_EQ_BIT  = 3;
  localparam int BJP_NE_BIT  = 2;
  localparam int BJP_LT_BIT  = 1;
  localparam int BJP_GT_BIT  = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  function automatic logic is_onehot4(input logic [3:0] f);
    return (f != 4'd0) && ((f & (f - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/qpu_exu_alu_req_arb_if.sv
// Request/response and datapath bundle around the shared ALU arbiter.
// slave = arbiter side, master = requestors plus datapath.
interface qpu_exu_alu_req_arb_if
  import qpu_exu_alu_arb_pkg::*;
#(
  parameter int XLEN = `QPU_XLEN
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*XLEN-1:0] req_op1;
  logic [NREQ*XLEN-1:0] req_op2;
  logic [NREQ*4-1:0]    req_func;

  logic [NREQ-1:0]      dp_sel;
  logic [XLEN-1:0]      dp_op1;
  logic [XLEN-1:0]      dp_op2;
  logic [3:0]           dp_alu_func;
  logic [3:0]           dp_bjp_func;
  logic [XLEN-1:0]      dp_res;
  logic                 dp_cmp_res;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [XLEN-1:0]      rsp_res;
  logic                 rsp_cmp;
  logic                 rsp_err;

  modport slave (
    input  req_valid, req_op1, req_op2, req_func, dp_res, dp_cmp_res, rsp_ready,
    output req_ready, dp_sel, dp_op1, dp_op2, dp_alu_func, dp_bjp_func,
           rsp_valid, rsp_id, rsp_res, rsp_cmp, rsp_err
  );

  modport master (
    output req_valid, req_op1, req_op2, req_func, dp_res, dp_cmp_res, rsp_ready,
    input  req_ready, dp_sel, dp_op1, dp_op2, dp_alu_func, dp_bjp_func,
           rsp_valid, rsp_id, rsp_res, rsp_cmp, rsp_err
  );

endinterface

// File: rtl/qpu_exu_alu_req_arb_rr.sv
// Four-way round-robin picker: search starts at the pointer, pointer moves
// one past the winner on every grant.
module qpu_rr_arb4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_req,
  input  logic       i_can_issue,
  output logic       o_grant,
  output logic [1:0] o_gnt_idx,
  output logic [3:0] o_gnt_oh
);

  logic [1:0] r_rr_ptr;
  logic       w_found;
  logic [1:0] w_pick;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr_ptr;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && i_req[r_rr_ptr + 2'(k)]) begin
        w_found = 1'b1;
        w_pick  = r_rr_ptr + 2'(k);
      end
    end
  end

  // Grant is suppressed while reset is held so nothing leaks to the datapath.
  assign o_grant   = w_found & i_can_issue & rst_n;
  assign o_gnt_idx = w_pick;
  assign o_gnt_oh  = o_grant ? (4'b0001 << w_pick) : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= 2'd0;
    end else if (o_grant) begin
      r_rr_ptr <= w_pick + 2'd1;
    end
  end

endmodule

// File: rtl/qpu_exu_alu_req_arb.sv
// Shared-ALU front end: arbitrates four EXU requestors, drives the datapath
// in the grant cycle and returns the registered result with the requestor id.
module qpu_exu_alu_req_arb
  import qpu_exu_alu_arb_pkg::*;
#(
  parameter int XLEN = `QPU_XLEN
) (
  input logic                  clk,
  input logic                  rst_n,
  qpu_exu_alu_req_arb_if.slave bus
);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_can_issue;
  logic            w_grant;
  logic [1:0]      w_gnt_idx;
  logic [NREQ-1:0] w_gnt_oh;

  logic [XLEN-1:0] w_op1_arr  [NREQ];
  logic [XLEN-1:0] w_op2_arr  [NREQ];
  logic [3:0]      w_func_arr [NREQ];
  logic [3:0]      w_func;
  logic            w_func_ok;
  logic            w_err;

  logic [1:0]      r_rsp_id;
  logic [XLEN-1:0] r_rsp_res;
  logic            r_rsp_cmp;
  logic            r_rsp_err;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_op1_arr[i]  = bus.req_op1[i*XLEN +: XLEN];
    assign w_op2_arr[i]  = bus.req_op2[i*XLEN +: XLEN];
    assign w_func_arr[i] = bus.req_func[i*4 +: 4];
  end

  // A full response register can only be refilled in the cycle it drains.
  assign w_can_issue = (r_state == ST_IDLE) | bus.rsp_ready;

  qpu_rr_arb4 u_rr_arb4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (bus.req_valid),
    .i_can_issue (w_can_issue),
    .o_grant     (w_grant),
    .o_gnt_idx   (w_gnt_idx),
    .o_gnt_oh    (w_gnt_oh)
  );

  assign w_func    = w_func_arr[w_gnt_idx];
  assign w_func_ok = is_onehot4(w_func);
  assign w_err     = (w_gnt_idx <= REQ_BJP) & ~w_func_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_state_nxt = ST_HOLD;
      ST_HOLD: if (bus.rsp_ready && !w_grant) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = w_gnt_oh;
    bus.dp_sel      = w_gnt_oh;
    bus.dp_op1      = '0;
    bus.dp_op2      = '0;
    bus.dp_alu_func = 4'd0;
    bus.dp_bjp_func = 4'd0;
    if (w_grant) begin
      bus.dp_op1 = w_op1_arr[w_gnt_idx];
      bus.dp_op2 = w_op2_arr[w_gnt_idx];
      // Malformed func never reaches the datapath; it is reported via rsp_err.
      if (w_gnt_idx == REQ_ALU && w_func_ok) bus.dp_alu_func = w_func;
      if (w_gnt_idx == REQ_BJP && w_func_ok) bus.dp_bjp_func = w_func;
    end
    bus.rsp_valid = (r_state == ST_HOLD);
    bus.rsp_id    = r_rsp_id;
    bus.rsp_res   = r_rsp_res;
    bus.rsp_cmp   = r_rsp_cmp;
    bus.rsp_err   = r_rsp_err;
  end

  // Without a grant the fields hold, which keeps a stalled response stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_id  <= 2'd0;
      r_rsp_res <= '0;
      r_rsp_cmp <= 1'b0;
      r_rsp_err <= 1'b0;
    end else if (w_grant) begin
      r_rsp_id  <= w_gnt_idx;
      r_rsp_res <= bus.dp_res;
      r_rsp_cmp <= bus.dp_cmp_res;
      r_rsp_err <= w_err;
    end
  end

endmodule

// File: tb/tb_qpu_exu_alu_req_arb.sv
// Self-checking bench for qpu_exu_alu_req_arb: vector table plus hand-written
// back-pressure, reset and round-robin sequences, responses via scoreboard.
module tb_qpu_exu_alu_req_arb;
  import qpu_exu_alu_arb_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  qpu_exu_alu_req_arb_if #(.XLEN(XLEN)) bus ();

  qpu_exu_alu_req_arb #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic        cmp;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [3:0]  valid;
    logic [1:0]  g;
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  rsp_t sb_q[$];
  vec_t vecs [14];

  function automatic logic onehot(input logic [3:0] f);
    return (f == 4'b0001) || (f == 4'b0010) || (f == 4'b0100) || (f == 4'b1000);
  endfunction

  // Datapath model: a non-one-hot ALU func falls back to subtraction.
  function automatic logic [31:0] alu_model(input logic [3:0] af, input logic [31:0] a,
                                            input logic [31:0] b);
    if (af == (4'b1 << ALU_ADD_BIT)) return a + b;
    if (af == (4'b1 << ALU_OR_BIT))  return a | b;
    if (af == (4'b1 << ALU_XOR_BIT)) return a ^ b;
    if (af == (4'b1 << ALU_AND_BIT)) return a & b;
    return a - b;
  endfunction

  function automatic logic cmp_model(input logic [3:0] bf, input logic [31:0] a,
                                     input logic [31:0] b);
    if (bf == (4'b1 << BJP_EQ_BIT)) return a == b;
    if (bf == (4'b1 << BJP_NE_BIT)) return a != b;
    if (bf == (4'b1 << BJP_LT_BIT)) return a < b;
    if (bf == (4'b1 << BJP_GT_BIT)) return a > b;
    return 1'b0;
  endfunction

  always_comb begin
    bus.dp_res     = alu_model(bus.dp_alu_func, bus.dp_op1, bus.dp_op2);
    bus.dp_cmp_res = cmp_model(bus.dp_bjp_func, bus.dp_op1, bus.dp_op2);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Target requestor gets a/b/f; the others get distinct decoy values.
  task automatic drive(input logic [3:0] v, input logic [1:0] tgt, input logic [3:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic rdy);
    bus.req_valid = v;
    bus.rsp_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      bus.req_op1[i*32 +: 32] = (i == int'(tgt)) ? a : a ^ (32'(i + 1) << 24);
      bus.req_op2[i*32 +: 32] = (i == int'(tgt)) ? b : b ^ (32'(i + 1) << 16);
      bus.req_func[i*4 +: 4]  = (i == int'(tgt)) ? f : 4'b1111;
    end
  endtask

  function automatic logic [31:0] all_op1(input int i); return 32'h100 + 32'(i); endfunction
  function automatic logic [31:0] all_op2(input int i); return 32'h10 * 32'(i);  endfunction
  function automatic logic [3:0]  all_fn(input int i);
    return (i == 0) ? 4'b1000 : (i == 1) ? 4'b0100 : 4'b0000;
  endfunction

  task automatic drive_all(input logic rdy);
    bus.req_valid = 4'b1111;
    bus.rsp_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      bus.req_op1[i*32 +: 32] = all_op1(i);
      bus.req_op2[i*32 +: 32] = all_op2(i);
      bus.req_func[i*4 +: 4]  = all_fn(i);
    end
  endtask

  task automatic expect_idle();
    check("req_ready_idle", 32'(bus.req_ready), 32'h0);
    check("dp_sel_idle", 32'(bus.dp_sel), 32'h0);
  endtask

  task automatic expect_grant(input logic [1:0] g, input logic [3:0] f,
                              input logic [31:0] a, input logic [31:0] b);
    logic [3:0] af;
    logic [3:0] bf;
    af = (g == REQ_ALU && onehot(f)) ? f : 4'b0000;
    bf = (g == REQ_BJP && onehot(f)) ? f : 4'b0000;
    check("req_ready", 32'(bus.req_ready), 32'(4'b0001 << g));
    check("dp_sel", 32'(bus.dp_sel), 32'(4'b0001 << g));
    check("dp_op1", bus.dp_op1, a);
    check("dp_op2", bus.dp_op2, b);
    check("dp_alu_func", 32'(bus.dp_alu_func), 32'(af));
    check("dp_bjp_func", 32'(bus.dp_bjp_func), 32'(bf));
    sb_q.push_back('{id: g, res: alu_model(af, a, b), cmp: cmp_model(bf, a, b),
                     err: (g <= REQ_BJP) && !onehot(f)});
  endtask

  // Response consumed on the coming edge: compare against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d res %h expected no response", bus.rsp_id,
                 bus.rsp_res);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        check("rsp_res", bus.rsp_res, e.res);
        check("rsp_cmp", 32'(bus.rsp_cmp), 32'(e.cmp));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic prev_g;

    vecs[0]  = '{4'b0001, REQ_ALU, 4'b1000, 32'd5,      32'd3};
    vecs[1]  = '{4'b0010, REQ_BJP, 4'b0010, 32'd2,      32'd7};
    vecs[2]  = '{4'b0000, REQ_ALU, 4'b0000, 32'd0,      32'd0};
    vecs[3]  = '{4'b0001, REQ_ALU, 4'b1010, 32'd9,      32'd1};
    vecs[4]  = '{4'b1111, REQ_BJP, 4'b1000, 32'hF0,     32'h0F};
    vecs[5]  = '{4'b1111, REQ_LSU, 4'b0000, 32'd100,    32'd4};
    vecs[6]  = '{4'b1111, REQ_QIU, 4'b1010, 32'd7,      32'd7};
    vecs[7]  = '{4'b1111, REQ_ALU, 4'b0001, 32'hFF00,   32'h0FF0};
    vecs[8]  = '{4'b1101, REQ_LSU, 4'b0000, 32'd10,     32'd20};
    vecs[9]  = '{4'b0101, REQ_ALU, 4'b0010, 32'hAAAA,   32'h5555};
    vecs[10] = '{4'b1010, REQ_BJP, 4'b0001, 32'd9,      32'd3};
    vecs[11] = '{4'b1010, REQ_QIU, 4'b0000, 32'd1,      32'd2};
    vecs[12] = '{4'b0010, REQ_BJP, 4'b0000, 32'd3,      32'd3};
    vecs[13] = '{4'b0100, REQ_LSU, 4'b1111, 32'h20,     32'h4};

    // Reset with everything requesting: nothing may be granted.
    rst_n = 1'b0;
    drive(4'b1111, REQ_ALU, 4'b1000, 32'd1, 32'd1, 1'b1);
    @(posedge clk); #1;
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
    check("rst_rsp_res", bus.rsp_res, 32'h0);
    check("rst_rsp_cmp", 32'(bus.rsp_cmp), 32'h0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_dp_sel", 32'(bus.dp_sel), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'b0000, REQ_ALU, 4'b0000, 32'd0, 32'd0, 1'b1);

    // Table: rsp_ready held high, one vector per cycle.
    prev_g = 1'b0;
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].valid, vecs[i].g, vecs[i].f, vecs[i].a, vecs[i].b, 1'b1);
      @(negedge clk);
      check("rsp_valid_flow", 32'(bus.rsp_valid), 32'(prev_g));
      if (vecs[i].valid != 4'b0000) expect_grant(vecs[i].g, vecs[i].f, vecs[i].a, vecs[i].b);
      else expect_idle();
      prev_g = (vecs[i].valid != 4'b0000);
    end

    // Back-pressure: ALU response stalls for three cycles while LSU waits.
    @(posedge clk); #1;
    drive(4'b0000, REQ_ALU, 4'b0000, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    expect_idle();
    @(posedge clk); #1;
    drive(4'b0001, REQ_ALU, 4'b1000, 32'd1, 32'd1, 1'b1);
    @(negedge clk);
    check("bp_idle_before", 32'(bus.rsp_valid), 32'h0);
    expect_grant(REQ_ALU, 4'b1000, 32'd1, 32'd1);
    @(posedge clk); #1;
    drive(4'b0100, REQ_LSU, 4'b0000, 32'h40, 32'h8, 1'b0);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      expect_idle();
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_rsp_id", 32'(bus.rsp_id), 32'h0);
      check("bp_rsp_res", bus.rsp_res, 32'h2);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    expect_grant(REQ_LSU, 4'b0000, 32'h40, 32'h8);
    @(posedge clk); #1;
    drive(4'b0000, REQ_ALU, 4'b0000, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    expect_idle();
    check("bp_lsu_rsp_id", 32'(bus.rsp_id), 32'(REQ_LSU));

    // Reset while holding a stalled response: it is dropped, pointer returns to 0.
    @(posedge clk); #1;
    drive(4'b0010, REQ_BJP, 4'b0100, 32'd3, 32'd4, 1'b1);
    @(negedge clk);
    check("hold_bjp_ready", 32'(bus.req_ready), 32'h2);
    @(posedge clk); #1;
    drive(4'b0000, REQ_ALU, 4'b0000, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    check("hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_all(1'b0);
    @(negedge clk);
    check("midrst_req_ready", 32'(bus.req_ready), 32'h0);
    check("midrst_dp_sel", 32'(bus.dp_sel), 32'h0);
    @(posedge clk); #1;
    check("midrst_rsp_drop", 32'(bus.rsp_valid), 32'h0);
    rst_n = 1'b1;
    drive_all(1'b1);

    // All four valid: grants 0,1,2,3,0 with no response gaps.
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      check("rr_rsp_valid", 32'(bus.rsp_valid), 32'(k > 0));
      expect_grant(2'(k % 4), all_fn(k % 4), all_op1(k % 4), all_op2(k % 4));
    end
    @(posedge clk); #1;
    drive(4'b0000, REQ_ALU, 4'b0000, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    expect_idle();
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
